// File: rtl/time_update_sched.sv
// Sequencer for a BCD-style time register: walks the datapath through
// load/add/write/check steps per field, rippling carries from seconds upward.
module time_update_sched #(
  parameter int unsigned LAST_FIELD = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       set_req,
  input  logic [1:0] set_field,
  input  logic       carry_in,
  output logic [1:0] field_sel,
  output logic       ld_a,
  output logic       ld_b,
  output logic       alu_en,
  output logic       wr_en,
  output logic       busy,
  output logic       set_ack,
  output logic       day_tick,
  output logic       missed_tick
);

  localparam int unsigned FW = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_ADD    = 3'd3,
    S_WRITE  = 3'd4,
    S_CHECK  = 3'd5
  } state_e;

  typedef enum logic {
    SRC_TICK = 1'b0,
    SRC_SET  = 1'b1
  } src_e;

  state_e        state_q, state_d;
  src_e          src_q, src_d;
  logic [FW-1:0] field_q, field_d;
  logic          pend_q, pend_d;
  logic          missed_q, missed_d;
  logic          ack_q, ack_d;
  logic          day_q, day_d;
  logic          ld_a_q, ld_a_d;
  logic          ld_b_q, ld_b_d;
  logic          alu_q, alu_d;
  logic          wr_q, wr_d;
  logic          busy_q, busy_d;
  logic          fld_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      src_q    <= SRC_TICK;
      field_q  <= '0;
      pend_q   <= 1'b0;
      missed_q <= 1'b0;
      ack_q    <= 1'b0;
      day_q    <= 1'b0;
      ld_a_q   <= 1'b0;
      ld_b_q   <= 1'b0;
      alu_q    <= 1'b0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      field_q  <= field_d;
      pend_q   <= pend_d;
      missed_q <= missed_d;
      ack_q    <= ack_d;
      day_q    <= day_d;
      ld_a_q   <= ld_a_d;
      ld_b_q   <= ld_b_d;
      alu_q    <= alu_d;
      wr_q     <= wr_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    field_d  = field_q;
    pend_d   = pend_q;
    missed_d = missed_q;
    ack_d    = 1'b0;
    day_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (tick || pend_q) begin
          // A fresh tick alongside a pending one keeps the pending slot full
          state_d = S_LOAD_A;
          src_d   = SRC_TICK;
          field_d = '0;
          pend_d  = tick && pend_q;
        end else if (set_req && !ack_q) begin
          state_d = S_LOAD_A;
          src_d   = SRC_SET;
          field_d = set_field;
        end
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_ADD;
      S_ADD:    state_d = S_WRITE;
      S_WRITE:  state_d = S_CHECK;
      S_CHECK: begin
        state_d = S_IDLE;
        if (src_q == SRC_SET) begin
          ack_d = 1'b1;
        end else if (carry_in) begin
          if (32'(field_q) < LAST_FIELD) begin
            field_d = FW'(field_q + FW'(1));
            state_d = S_LOAD_A;
          end else begin
            day_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && tick) begin
      if (pend_q) missed_d = 1'b1;
      else        pend_d   = 1'b1;
    end

    // Fields beyond the chain are acknowledged without touching the datapath
    fld_ok = (32'(field_d) <= LAST_FIELD);
    ld_a_d = (state_d == S_LOAD_A) && fld_ok;
    ld_b_d = (state_d == S_LOAD_B) && fld_ok;
    alu_d  = (state_d == S_ADD)    && fld_ok;
    wr_d   = (state_d == S_WRITE)  && fld_ok;
    busy_d = (state_d != S_IDLE);
  end

  assign field_sel   = field_q;
  assign ld_a        = ld_a_q;
  assign ld_b        = ld_b_q;
  assign alu_en      = alu_q;
  assign wr_en       = wr_q;
  assign busy        = busy_q;
  assign set_ack     = ack_q;
  assign day_tick    = day_q;
  assign missed_tick = missed_q;

endmodule

// File: tb/tb_time_update_sched.sv
// Bench for time_update_sched: directed scenarios plus a randomized run
// checked against a transaction-level model of the update sequencing.
module tb_time_update_sched;

  localparam int LAST = 2;

  logic       clk = 1'b0;
  logic       rst_n, tick, set_req, carry_in;
  logic [1:0] set_field;
  logic [1:0] field_sel;
  logic       ld_a, ld_b, alu_en, wr_en, busy, set_ack, day_tick, missed_tick;
  logic [8:0] outv;

  int total = 0;
  int bad   = 0;

  time_update_sched #(.LAST_FIELD(LAST)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .set_req(set_req),
    .set_field(set_field), .carry_in(carry_in), .field_sel(field_sel),
    .ld_a(ld_a), .ld_b(ld_b), .alu_en(alu_en), .wr_en(wr_en), .busy(busy),
    .set_ack(set_ack), .day_tick(day_tick), .missed_tick(missed_tick)
  );

  always #5 clk = ~clk;

  assign outv = {field_sel, ld_a, ld_b, alu_en, wr_en, busy, set_ack, day_tick};

  // Expected {field_sel, strobes, busy, ack, day} for cycle ph (1..5) of a field pass
  function automatic logic [8:0] pass_vec(int f, int ph);
    logic ok;
    ok = (f <= LAST);
    return {2'(f), ok && ph == 1, ok && ph == 2, ok && ph == 3, ok && ph == 4,
            1'b1, 1'b0, 1'b0};
  endfunction

  function automatic logic [8:0] idle_vec(int f, logic ack, logic day);
    return {2'(f), 5'b00000, ack, day};
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick = 1'b0; set_req = 1'b0; set_field = 2'd0; carry_in = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick = 1'b0; set_req = 1'b0; set_field = 2'd0; carry_in = 1'b0;
    #1;
    total++;
    if ({outv, missed_tick} !== 10'd0) begin
      bad++; $display("FAIL reset_t0 got=%h exp=%h", {outv, missed_tick}, 10'd0);
    end
    tick = 1'b1;
    cyc(); cyc();
    total++;
    if ({outv, missed_tick} !== 10'd0) begin
      bad++; $display("FAIL reset_held got=%h exp=%h", {outv, missed_tick}, 10'd0);
    end
    rst_n = 1'b1;
    cyc();
    tick = 1'b0;
    total++;
    if (outv !== pass_vec(0, 1)) begin
      bad++; $display("FAIL first_grant got=%h exp=%h", outv, pass_vec(0, 1));
    end
  endtask

  task automatic test_single_tick();
    logic [8:0] e;
    do_reset();
    tick = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      tick = 1'b0;
      e = (k <= 5) ? pass_vec(0, k) : idle_vec(0, 1'b0, 1'b0);
      total++;
      if (outv !== e) begin
        bad++; $display("FAIL single_tick k=%0d got=%h exp=%h", k, outv, e);
      end
    end
  endtask

  task automatic test_carry_chain();
    logic [8:0] e;
    do_reset();
    carry_in = 1'b1;
    tick = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      cyc();
      tick = 1'b0;
      e = (k <= 15) ? pass_vec((k - 1) / 5, (k - 1) % 5 + 1) : idle_vec(2, 1'b0, k == 16);
      total++;
      if (outv !== e) begin
        bad++; $display("FAIL carry_chain k=%0d got=%h exp=%h", k, outv, e);
      end
    end
    carry_in = 1'b0;
  endtask

  task automatic test_tick_and_set();
    logic [8:0] e;
    do_reset();
    tick = 1'b1; set_req = 1'b1; set_field = 2'd1;
    for (int k = 1; k <= 13; k++) begin
      cyc();
      tick = 1'b0;
      if (k <= 5)       e = pass_vec(0, k);
      else if (k == 6)  e = idle_vec(0, 1'b0, 1'b0);
      else if (k <= 11) e = pass_vec(1, k - 6);
      else              e = idle_vec(1, k == 12, 1'b0);
      total++;
      if (outv !== e) begin
        bad++; $display("FAIL tick_and_set k=%0d got=%h exp=%h", k, outv, e);
      end
      if (k == 12) set_req = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] e;
    do_reset();
    tick = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      cyc();
      if (k <= 5)       e = {pass_vec(0, k), k >= 4};
      else if (k == 6)  e = {idle_vec(0, 1'b0, 1'b0), 1'b1};
      else if (k <= 11) e = {pass_vec(0, k - 6), 1'b1};
      else              e = {idle_vec(0, 1'b0, 1'b0), 1'b1};
      total++;
      if ({outv, missed_tick} !== e) begin
        bad++; $display("FAIL back_to_back k=%0d got=%h exp=%h", k, {outv, missed_tick}, e);
      end
      tick = (k == 2 || k == 3);
    end
  endtask

  task automatic test_set_field(input logic [1:0] f, input logic cin);
    logic [8:0] e;
    do_reset();
    set_req = 1'b1; set_field = f; carry_in = cin;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      e = (k <= 5) ? pass_vec(int'(f), k) : idle_vec(int'(f), k == 6, 1'b0);
      total++;
      if (outv !== e) begin
        bad++; $display("FAIL set_field f=%0d k=%0d got=%h exp=%h", f, k, outv, e);
      end
      if (k == 6) set_req = 1'b0;
    end
    carry_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc(); cyc();
    total++;
    if (outv !== pass_vec(0, 3)) begin
      bad++; $display("FAIL mid_add got=%h exp=%h", outv, pass_vec(0, 3));
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({outv, missed_tick} !== 10'd0) begin
      bad++; $display("FAIL async_reset got=%h exp=%h", {outv, missed_tick}, 10'd0);
    end
    cyc();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      total++;
      if ({outv, missed_tick} !== 10'd0) begin
        bad++; $display("FAIL post_reset k=%0d got=%h exp=%h", k, {outv, missed_tick}, 10'd0);
      end
    end
  endtask

  // Reference model: one job at a time, counted in 5-cycle field passes
  logic m_busy, m_tick_job, m_ack, m_day, m_missed;
  int   m_ph, m_f, m_pend;

  task automatic model_reset();
    m_busy = 0; m_tick_job = 1; m_ack = 0; m_day = 0; m_missed = 0;
    m_ph = 0; m_f = 0; m_pend = 0;
  endtask

  function automatic logic [9:0] model_vec();
    logic ok;
    ok = m_busy && (m_f <= LAST);
    return {2'(m_f), ok && m_ph == 1, ok && m_ph == 2, ok && m_ph == 3, ok && m_ph == 4,
            m_busy, m_ack, m_day, m_missed};
  endfunction

  task automatic model_step(input logic t, input logic sr, input logic [1:0] sf, input logic c);
    logic ack_now;
    ack_now = m_ack;
    m_ack = 0;
    m_day = 0;
    if (!m_busy) begin
      if (t || m_pend > 0) begin
        m_pend = m_pend + int'(t) - 1;
        m_busy = 1; m_ph = 1; m_f = 0; m_tick_job = 1;
      end else if (sr && !ack_now) begin
        m_busy = 1; m_ph = 1; m_f = int'(sf); m_tick_job = 0;
      end
    end else begin
      if (t) begin
        if (m_pend > 0) m_missed = 1;
        else            m_pend = 1;
      end
      if (m_ph < 5) begin
        m_ph++;
      end else if (!m_tick_job) begin
        m_busy = 0; m_ack = 1;
      end else if (c && m_f < LAST) begin
        m_f++; m_ph = 1;
      end else begin
        m_busy = 0; m_day = c;
      end
    end
  endtask

  task automatic test_random();
    logic [9:0] e;
    do_reset();
    model_reset();
    for (int i = 0; i < 4000; i++) begin
      e = model_vec();
      total++;
      if ({outv, missed_tick} !== e) begin
        bad++; $display("FAIL random i=%0d got=%h exp=%h", i, {outv, missed_tick}, e);
      end
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0; tick = 1'b0; set_req = 1'b0;
        model_reset();
      end else begin
        rst_n = 1'b1;
        tick = ($urandom_range(0, 5) == 0);
        carry_in = 1'($urandom_range(0, 1));
        if (set_req && set_ack) begin
          set_req = 1'b0;
        end else if (!set_req && $urandom_range(0, 3) == 0) begin
          set_req = 1'b1;
          set_field = 2'($urandom_range(0, 3));
        end
        model_step(tick, set_req, set_field, carry_in);
      end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_single_tick();
    test_carry_chain();
    test_tick_and_set();
    test_back_to_back();
    test_set_field(2'd1, 1'b1);
    test_set_field(2'd3, 1'b0);
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
